// File: rtl/addsub_serial.sv
// addsub_serial: digit-serial adder/subtractor. Consumes DIGIT bits per clock,
// least-significant slice first, so only a DIGIT-wide carry chain sits between
// registers. Start/busy/done handshake with registered sum and flags.

// One DIGIT-wide slice of the adder: {co, s} = a + b + ci.
module addsub_digit #(
    parameter int DIGIT = 2
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             ci,
    output logic [DIGIT-1:0] s,
    output logic             co
);
    assign {co, s} = {1'b0, a} + {1'b0, b} + {{DIGIT{1'b0}}, ci};
endmodule

module addsub_serial #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             ovf,
    output logic             zero
);
    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic             accept;
    logic             last;
    // Operands are shifted right one slice per cycle so the active slice is
    // always at bit 0; b_sh already holds ~b for subtract.
    logic [WIDTH-1:0] a_sh, b_sh;
    // Original adder-input MSBs, kept for the overflow test after shifting.
    logic             a_msb, b_msb;
    logic             mode_q;
    logic             cy_q;
    logic [CW-1:0]    cnt;
    logic [DIGIT-1:0] s_dig;
    logic             co_dig;
    logic [WIDTH-1:0] sum_nx;

    addsub_digit #(.DIGIT(DIGIT)) u_digit (
        .a  (a_sh[DIGIT-1:0]),
        .b  (b_sh[DIGIT-1:0]),
        .ci (cy_q),
        .s  (s_dig),
        .co (co_dig)
    );

    assign last = (cnt == CW'(NDIG - 1));
    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state: accept start only when not running; DONE lasts one cycle.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                accept  = 1'b1;
                state_d = RUN;
            end
            RUN:  if (last) state_d = DONE;
            DONE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Full sum as it will look once the current slice is written; used both
    // for the slice write-back and for the zero flag on the final slice.
    always_comb begin
        sum_nx = sum;
        for (int i = 0; i < NDIG; i++) begin
            if (cnt == CW'(i)) sum_nx[i*DIGIT +: DIGIT] = s_dig;
        end
    end

    // Datapath: latch at accept, then one slice per RUN cycle; flags only
    // change on the final slice. The top-slice carry goes to carry/borrow and
    // is never recirculated.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            mode_q <= 1'b0;
            cy_q   <= 1'b0;
            cnt    <= '0;
            sum    <= '0;
            carry  <= 1'b0;
            ovf    <= 1'b0;
            zero   <= 1'b0;
        end else if (accept) begin
            a_sh   <= a;
            b_sh   <= mode ? ~b : b;
            a_msb  <= a[WIDTH-1];
            b_msb  <= mode ? ~b[WIDTH-1] : b[WIDTH-1];
            mode_q <= mode;
            cy_q   <= mode ? ~cin : cin;
            cnt    <= '0;
        end else if (state_q == RUN) begin
            a_sh <= a_sh >> DIGIT;
            b_sh <= b_sh >> DIGIT;
            cy_q <= co_dig;
            cnt  <= cnt + CW'(1);
            sum  <= sum_nx;
            if (last) begin
                carry <= co_dig ^ mode_q;
                ovf   <= (a_msb == b_msb) && (s_dig[DIGIT-1] != a_msb);
                zero  <= (sum_nx == '0);
            end
        end
    end
endmodule

// File: tb/tb_addsub_serial.sv
// Testbench for addsub_serial: scoreboard of expected results per instance,
// 8/2 handshake scenarios, exhaustive 4/4 and random 16/4 sweeps.
module tb_addsub_serial;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    typedef struct {
        longint sum;
        bit     carry;
        bit     ovf;
        bit     zero;
    } exp_t;

    exp_t q8[$], q4[$], q16[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    // WIDTH=8, DIGIT=2
    logic       start8, mode8, cin8;
    logic [7:0] a8, b8, sum8;
    logic       busy8, done8, carry8, ovf8, zero8;
    addsub_serial #(.WIDTH(8), .DIGIT(2)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .mode(mode8), .a(a8), .b(b8),
        .cin(cin8), .busy(busy8), .done(done8), .sum(sum8), .carry(carry8),
        .ovf(ovf8), .zero(zero8));

    // WIDTH=4, DIGIT=4 (single-cycle RUN)
    logic       start4, mode4, cin4;
    logic [3:0] a4, b4, sum4;
    logic       busy4, done4, carry4, ovf4, zero4;
    addsub_serial #(.WIDTH(4), .DIGIT(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .mode(mode4), .a(a4), .b(b4),
        .cin(cin4), .busy(busy4), .done(done4), .sum(sum4), .carry(carry4),
        .ovf(ovf4), .zero(zero4));

    // WIDTH=16, DIGIT=4
    logic        start16, mode16, cin16;
    logic [15:0] a16, b16, sum16;
    logic        busy16, done16, carry16, ovf16, zero16;
    addsub_serial #(.WIDTH(16), .DIGIT(4)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .mode(mode16), .a(a16), .b(b16),
        .cin(cin16), .busy(busy16), .done(done16), .sum(sum16), .carry(carry16),
        .ovf(ovf16), .zero(zero16));

    // Reference: integer arithmetic, signed overflow from the true signed result.
    function automatic exp_t model(int w, longint av, longint bv, bit m, bit c);
        exp_t   e;
        longint full, half, sa, sb, s, r;
        full = longint'(1) << w;
        half = full >> 1;
        sa = (av >= half) ? av - full : av;
        sb = (bv >= half) ? bv - full : bv;
        if (!m) begin
            r = av + bv + longint'(c);
            e.carry = (r >= full);
            s = sa + sb + longint'(c);
        end else begin
            r = av - bv - longint'(c);
            e.carry = (av < bv + longint'(c));
            s = sa - sb - longint'(c);
        end
        e.sum  = r & (full - 1);
        e.ovf  = (s >= half) || (s < -half);
        e.zero = (e.sum == 0);
        return e;
    endfunction

    task automatic launch8(input logic [7:0] av, input logic [7:0] bv, input bit m,
                           input bit c, input exp_t e);
        @(negedge clk);
        a8 = av; b8 = bv; mode8 = m; cin8 = c; start8 = 1'b1;
        q8.push_back(e);
        @(negedge clk);
        start8 = 1'b0;
    endtask

    // Bounded wait for done; n counts negedges since the accepting edge.
    task automatic wait8(input int n0, output int n, output int bc);
        n = n0; bc = 0;
        while (!done8 && n < 40) begin
            if (busy8) bc++;
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset;
        n_chk++;
        if ({busy8, done8, sum8, carry8, ovf8, zero8} !== 13'b0) begin
            $display("FAIL reset8: busy=%b done=%b sum=%h c/v/z=%b%b%b, want all 0",
                     busy8, done8, sum8, carry8, ovf8, zero8);
        end else n_pass++;
        n_chk++;
        if ({busy4, done4, sum4, busy16, done16, sum16} !== 24'b0) begin
            $display("FAIL reset4_16: busy4=%b done4=%b sum4=%h busy16=%b done16=%b sum16=%h, want 0",
                     busy4, done4, sum4, busy16, done16, sum16);
        end else n_pass++;
    endtask

    // Table-driven add/sub with constant expectations.
    task automatic run_table8(input string name, input logic [7:0] ta[3], input logic [7:0] tb[3],
                              input bit m, input bit tc[3], input logic [7:0] es[3],
                              input bit ec[3], input bit ev[3], input bit ez[3]);
        int   n, bc;
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            e.sum = es[i]; e.carry = ec[i]; e.ovf = ev[i]; e.zero = ez[i];
            launch8(ta[i], tb[i], m, tc[i], e);
            wait8(1, n, bc);
            n_chk++;
            if (n != 5 || bc != 4) $display("FAIL %s[%0d] latency: done_at=%0d busy_cycles=%0d, want 5 and 4", name, i, n, bc);
            else n_pass++;
            e = q8.pop_front();
            n_chk++;
            if (done8 !== 1'b1 || sum8 !== e.sum[7:0] || {carry8, ovf8, zero8} !== {e.carry, e.ovf, e.zero})
                $display("FAIL %s[%0d]: done=%b sum=%h c/v/z=%b%b%b, want done=1 sum=%h c/v/z=%b%b%b",
                         name, i, done8, sum8, carry8, ovf8, zero8, e.sum[7:0], e.carry, e.ovf, e.zero);
            else n_pass++;
        end
    endtask

    task automatic test_add;
        run_table8("add", '{8'h0D, 8'hFF, 8'h7F}, '{8'h0D, 8'h01, 8'h01}, 1'b0, '{0, 0, 0},
                   '{8'h1A, 8'h00, 8'h80}, '{0, 1, 0}, '{0, 0, 1}, '{0, 1, 0});
    endtask

    task automatic test_sub;
        run_table8("sub", '{8'h7F, 8'h05, 8'h05}, '{8'hFF, 8'h05, 8'h05}, 1'b1, '{0, 1, 0},
                   '{8'h80, 8'hFF, 8'h00}, '{1, 1, 0}, '{1, 0, 0}, '{0, 0, 1});
    endtask

    // start and operand changes during RUN must not disturb the operation.
    task automatic test_start_ignored;
        int   n, bc;
        exp_t e;
        e.sum = 8'h78; e.carry = 0; e.ovf = 0; e.zero = 0;
        launch8(8'h55, 8'h22, 1'b0, 1'b1, e);
        @(negedge clk);
        start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; mode8 = 1'b1; cin8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0; a8 = 8'h00; b8 = 8'h13;
        wait8(3, n, bc);
        e = q8.pop_front();
        n_chk++;
        if (n != 5 || done8 !== 1'b1 || sum8 !== e.sum[7:0] || {carry8, ovf8, zero8} !== {e.carry, e.ovf, e.zero})
            $display("FAIL ignored_start: done_at=%0d done=%b sum=%h c/v/z=%b%b%b, want 5 1 %h %b%b%b",
                     n, done8, sum8, carry8, ovf8, zero8, e.sum[7:0], e.carry, e.ovf, e.zero);
        else n_pass++;
        @(negedge clk);
        n_chk++;
        if (done8 !== 1'b0 || busy8 !== 1'b0 || sum8 !== 8'h78)
            $display("FAIL idle_hold: done=%b busy=%b sum=%h, want 0 0 78", done8, busy8, sum8);
        else n_pass++;
    endtask

    task automatic test_back_to_back;
        int   n, bc;
        exp_t e, e2;
        e.sum = 8'h00; e.carry = 1; e.ovf = 1; e.zero = 1;
        launch8(8'h80, 8'h80, 1'b0, 1'b0, e);
        wait8(1, n, bc);
        e = q8.pop_front();
        n_chk++;
        if (done8 !== 1'b1 || sum8 !== e.sum[7:0] || {carry8, ovf8, zero8} !== {e.carry, e.ovf, e.zero})
            $display("FAIL b2b_first: done=%b sum=%h c/v/z=%b%b%b, want 1 %h %b%b%b",
                     done8, sum8, carry8, ovf8, zero8, e.sum[7:0], e.carry, e.ovf, e.zero);
        else n_pass++;
        // Start in the DONE cycle.
        e2.sum = 8'hE0; e2.carry = 1; e2.ovf = 0; e2.zero = 0;
        a8 = 8'h10; b8 = 8'h30; mode8 = 1'b1; cin8 = 1'b0; start8 = 1'b1;
        q8.push_back(e2);
        @(negedge clk);
        start8 = 1'b0;
        n_chk++;
        if (busy8 !== 1'b1 || done8 !== 1'b0)
            $display("FAIL b2b_accept: busy=%b done=%b, want 1 0", busy8, done8);
        else n_pass++;
        wait8(1, n, bc);
        e2 = q8.pop_front();
        n_chk++;
        if (n != 5 || done8 !== 1'b1 || sum8 !== e2.sum[7:0] || {carry8, ovf8, zero8} !== {e2.carry, e2.ovf, e2.zero})
            $display("FAIL b2b_second: done_at=%0d done=%b sum=%h c/v/z=%b%b%b, want 5 1 %h %b%b%b",
                     n, done8, sum8, carry8, ovf8, zero8, e2.sum[7:0], e2.carry, e2.ovf, e2.zero);
        else n_pass++;
    endtask

    task automatic test_reset_midrun;
        int   n, bc, dcnt;
        exp_t e;
        e = model(8, 64'h0D, 64'h0D, 1'b0, 1'b0);
        launch8(8'h0D, 8'h0D, 1'b0, 1'b0, e);
        @(negedge clk);                       // RUN cycle 2, slice 0 already written
        #1 rst_n = 1'b0;
        #1;
        n_chk++;
        if ({busy8, done8, sum8, carry8, ovf8, zero8} !== 13'b0)
            $display("FAIL reset_midrun: busy=%b done=%b sum=%h c/v/z=%b%b%b, want all 0",
                     busy8, done8, sum8, carry8, ovf8, zero8);
        else n_pass++;
        void'(q8.pop_back());
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        dcnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (done8 || busy8) dcnt++;
            @(negedge clk);
        end
        n_chk++;
        if (dcnt != 0) $display("FAIL reset_no_done: active_cycles=%0d, want 0", dcnt);
        else n_pass++;
        e = model(8, 64'hC3, 64'h5A, 1'b1, 1'b1);
        launch8(8'hC3, 8'h5A, 1'b1, 1'b1, e);
        wait8(1, n, bc);
        e = q8.pop_front();
        n_chk++;
        if (n != 5 || sum8 !== e.sum[7:0] || {carry8, ovf8, zero8} !== {e.carry, e.ovf, e.zero})
            $display("FAIL reset_fresh: done_at=%0d sum=%h c/v/z=%b%b%b, want 5 %h %b%b%b",
                     n, sum8, carry8, ovf8, zero8, e.sum[7:0], e.carry, e.ovf, e.zero);
        else n_pass++;
    endtask

    // Exhaustive 4-bit, single-cycle RUN: done two negedges after accept.
    task automatic test_sweep4;
        int   n;
        exp_t e;
        for (int ai = 0; ai < 16; ai++)
            for (int bi = 0; bi < 16; bi++)
                for (int m = 0; m < 2; m++)
                    for (int c = 0; c < 2; c++) begin
                        @(negedge clk);
                        a4 = ai[3:0]; b4 = bi[3:0]; mode4 = m[0]; cin4 = c[0]; start4 = 1'b1;
                        q4.push_back(model(4, longint'(ai), longint'(bi), m[0], c[0]));
                        @(negedge clk);
                        start4 = 1'b0;
                        n = 1;
                        while (!done4 && n < 20) begin
                            @(negedge clk);
                            n++;
                        end
                        e = q4.pop_front();
                        n_chk++;
                        if (n != 2 || sum4 !== e.sum[3:0] || {carry4, ovf4, zero4} !== {e.carry, e.ovf, e.zero})
                            $display("FAIL w4 a=%h b=%h m=%0d c=%0d: done_at=%0d sum=%h c/v/z=%b%b%b, want 2 %h %b%b%b",
                                     ai, bi, m, c, n, sum4, carry4, ovf4, zero4, e.sum[3:0], e.carry, e.ovf, e.zero);
                        else n_pass++;
                    end
    endtask

    // Random 16-bit; inputs scrambled after accept.
    task automatic test_sweep16;
        int          n, bc;
        exp_t        e;
        logic [15:0] av, bv;
        bit          m, c;
        for (int i = 0; i < 250; i++) begin
            av = 16'($urandom); bv = 16'($urandom);
            m = 1'($urandom); c = 1'($urandom);
            if (i == 0) begin av = 16'hFFFF; bv = 16'h0000; m = 1'b0; c = 1'b1; end
            if (i == 1) begin av = 16'h8000; bv = 16'h0001; m = 1'b1; c = 1'b0; end
            @(negedge clk);
            a16 = av; b16 = bv; mode16 = m; cin16 = c; start16 = 1'b1;
            q16.push_back(model(16, longint'(av), longint'(bv), m, c));
            @(negedge clk);
            start16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom); cin16 = ~c;
            n = 1; bc = 0;
            while (!done16 && n < 40) begin
                if (busy16) bc++;
                @(negedge clk);
                n++;
            end
            e = q16.pop_front();
            n_chk++;
            if (n != 5 || bc != 4 || sum16 !== e.sum[15:0] || {carry16, ovf16, zero16} !== {e.carry, e.ovf, e.zero})
                $display("FAIL w16[%0d] a=%h b=%h m=%0d c=%0d: done_at=%0d busy=%0d sum=%h c/v/z=%b%b%b, want 5 4 %h %b%b%b",
                         i, av, bv, m, c, n, bc, sum16, carry16, ovf16, zero16, e.sum[15:0], e.carry, e.ovf, e.zero);
            else n_pass++;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start8 = 0; mode8 = 0; cin8 = 0; a8 = '0; b8 = '0;
        start4 = 0; mode4 = 0; cin4 = 0; a4 = '0; b4 = '0;
        start16 = 0; mode16 = 0; cin16 = 0; a16 = '0; b16 = '0;
        repeat (3) @(negedge clk);
        test_reset;
        rst_n = 1'b1;
        test_add;
        test_sub;
        test_start_ignored;
        test_back_to_back;
        test_reset_midrun;
        test_sweep4;
        test_sweep16;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
